// File: rtl/cog_ctr_sweep.sv
// Frequency-sweep sequencer for one cog counter: programs the mode, steps the frequency,
// dwells per step and captures the accumulated phase into a small result FIFO.
module cog_ctr_sweep #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DWELL_W    = 16,
    parameter int unsigned STEP_W     = 8
) (
    input  logic               clk_cog,
    input  logic               nres,
    input  logic [31:0]        cfg_ctr,
    input  logic [31:0]        cfg_frq_start,
    input  logic [31:0]        cfg_frq_step,
    input  logic [STEP_W-1:0]  cfg_steps,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               setctr,
    output logic               setfrq,
    output logic               setphs,
    output logic [31:0]        data,
    input  logic [32:0]        phs,
    output logic [31:0]        res_data,
    output logic               res_valid,
    input  logic               res_rd,
    output logic               res_ovf
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        StIdle, StCfgCtr, StCfgFrq, StClrPhs, StDwell, StCapture, StNext, StFinish
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        ctr_q, frq_step_q;
    logic [31:0]        cur_frq_q, cur_frq_d;
    logic [STEP_W-1:0]  steps_q, steps_d;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic               ovf_q, ovf_d;
    logic               load_cfg, push, pop, full;

    logic [31:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q;

    // Only the low 32 bits of the phase accumulator are captured.
    logic unused_phs_msb;
    assign unused_phs_msb = phs[32];

    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign pop       = res_rd && (count_q != '0);
    assign res_valid = (count_q != '0);
    assign res_data  = mem_q[rd_ptr_q];
    assign res_ovf   = ovf_q;

    always_comb begin
        state_d     = state_q;
        cur_frq_d   = cur_frq_q;
        steps_d     = steps_q;
        dwell_cnt_d = dwell_cnt_q;
        ovf_d       = ovf_q;
        load_cfg    = 1'b0;
        push        = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        setctr      = 1'b0;
        setfrq      = 1'b0;
        setphs      = 1'b0;
        data        = '0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    load_cfg  = 1'b1;
                    ovf_d     = 1'b0;
                    cur_frq_d = cfg_frq_start;
                    steps_d   = cfg_steps;
                    state_d   = (cfg_steps == '0) ? StFinish : StCfgCtr;
                end
            end
            StCfgCtr: begin
                setctr  = 1'b1;
                data    = ctr_q;
                state_d = abort ? StFinish : StCfgFrq;
            end
            StCfgFrq: begin
                setfrq  = 1'b1;
                data    = cur_frq_q;
                state_d = abort ? StFinish : StClrPhs;
            end
            StClrPhs: begin
                setphs      = 1'b1;
                dwell_cnt_d = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
                state_d     = abort ? StFinish : StDwell;
            end
            StDwell: begin
                dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                if (abort) begin
                    state_d = StFinish;
                end else if (dwell_cnt_q <= DWELL_W'(1)) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                if (abort) begin
                    state_d = StFinish;
                end else if (!full || pop) begin
                    push    = 1'b1;
                    state_d = (steps_q == STEP_W'(1)) ? StFinish : StNext;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            StNext: begin
                if (abort) begin
                    state_d = StFinish;
                end else begin
                    cur_frq_d = cur_frq_q + frq_step_q;
                    steps_d   = steps_q - STEP_W'(1);
                    state_d   = StCfgFrq;
                end
            end
            StFinish: begin
                // Writing mode 0 turns the counter off.
                setctr  = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                busy    = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            state_q     <= StIdle;
            ctr_q       <= '0;
            frq_step_q  <= '0;
            dwell_q     <= '0;
            cur_frq_q   <= '0;
            steps_q     <= '0;
            dwell_cnt_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_frq_q   <= cur_frq_d;
            steps_q     <= steps_d;
            dwell_cnt_q <= dwell_cnt_d;
            ovf_q       <= ovf_d;
            if (load_cfg) begin
                ctr_q      <= cfg_ctr;
                frq_step_q <= cfg_frq_step;
                dwell_q    <= cfg_dwell;
            end
        end
    end

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= phs[31:0];
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
